// File: rtl/mult_rs_pkg.sv
// Shared types and widths for the multiply reservation station.
package rs_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 8;

  // One reservation-station slot: the op payload plus per-source wakeup state.
  typedef struct packed {
    logic                   valid;
    logic [DATA_W-1:0]      operand;
    logic [1:0]             rdy;
    logic [1:0][TAG_W-1:0]  tag;
    logic [1:0][DATA_W-1:0] val;
    logic [DATA_W-1:0]      wbs;
    logic [DATA_W-1:0]      flags;
    logic [TAG_W-1:0]       robid;
  } rs_entry_t;

endpackage

// File: rtl/mult_rs_if.sv
// Dispatch, CDB snoop, and FU issue bundle for mult_rs.
// master = the surrounding core (dispatch/CDB/FU side), slave = the station.
interface mult_rs_if
  import rs_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                   dispatch_transmit;
  logic                   dispatch_ready;
  logic [DATA_W-1:0]      disp_operand;
  logic [1:0]             disp_src_ready;
  logic [1:0][TAG_W-1:0]  disp_src_tag;
  logic [1:0][DATA_W-1:0] disp_src_val;
  logic [DATA_W-1:0]      disp_wbs;
  logic [DATA_W-1:0]      disp_flags;
  logic [TAG_W-1:0]       disp_robid;

  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_id;
  logic [DATA_W-1:0]      cdb_val;

  logic                   fu_busy;
  logic                   issue_transmit;
  logic [DATA_W-1:0]      issue_operand;
  logic [1:0][DATA_W-1:0] issue_depvals;
  logic [DATA_W-1:0]      issue_wbs;
  logic [DATA_W-1:0]      issue_flags;
  logic [TAG_W-1:0]       issue_robid;
  logic [OCC_W-1:0]       occupancy;

  modport master (
    output dispatch_transmit, disp_operand, disp_src_ready, disp_src_tag,
           disp_src_val, disp_wbs, disp_flags, disp_robid,
           cdb_valid, cdb_id, cdb_val, fu_busy,
    input  dispatch_ready, issue_transmit, issue_operand, issue_depvals,
           issue_wbs, issue_flags, issue_robid, occupancy
  );

  modport slave (
    input  dispatch_transmit, disp_operand, disp_src_ready, disp_src_tag,
           disp_src_val, disp_wbs, disp_flags, disp_robid,
           cdb_valid, cdb_id, cdb_val, fu_busy,
    output dispatch_ready, issue_transmit, issue_operand, issue_depvals,
           issue_wbs, issue_flags, issue_robid, occupancy
  );

endinterface

// File: rtl/mult_rs_oldest_pick.sv
// Oldest-first selector: grants the eligible entry that no other eligible
// entry is older than. The age matrix is a strict order, so the grant is one-hot.
module rs_oldest_pick #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            elig,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        any_grant
);

  // An entry wins unless some other eligible entry predates it.
  always_comb begin
    grant = elig;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && elig[j] && older[j][i]) grant[i] = 1'b0;
      end
    end
    any_grant = |elig;
  end

endmodule

// File: rtl/mult_rs.sv
// Reservation station in front of the multiply FU. Holds dispatched ops until
// both sources are resolved (snooping the CDB), then issues the oldest ready
// op as a registered one-cycle pulse while the FU is idle.
// Optional: define MULT_RS_FLUSH_EN to add a synchronous flush input.
module mult_rs
  import rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
`ifdef MULT_RS_FLUSH_EN
  input  logic     flush,
`endif
  mult_rs_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  rs_entry_t                   ent [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0] older;
  logic [DEPTH-1:0][DEPTH-1:0] older_nxt;
  logic [OCC_W-1:0]            occ;

  logic                        tx;
  logic [DATA_W-1:0]           out_operand;
  logic [1:0][DATA_W-1:0]      out_depvals;
  logic [DATA_W-1:0]           out_wbs;
  logic [DATA_W-1:0]           out_flags;
  logic [TAG_W-1:0]            out_robid;

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            elig;
  logic [DEPTH-1:0]            grant;
  logic [DEPTH-1:0]            free_oh;
  logic                        any_grant;
  logic                        issue_fire;
  logic                        disp_fire;
  logic                        flush_now;
  rs_entry_t                   sel;
  rs_entry_t                   new_ent;

`ifdef MULT_RS_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Readiness is taken from registered rdy bits only, so a CDB wakeup is
  // visible to the picker one cycle later.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld[i]  = ent[i].valid;
      elig[i] = ent[i].valid & (&ent[i].rdy);
    end
  end

  rs_oldest_pick #(.DEPTH(DEPTH)) u_pick (
    .elig      (elig),
    .older     (older),
    .grant     (grant),
    .any_grant (any_grant)
  );

  // Fullness comes from current state; a same-cycle issue does not help.
  assign bus.dispatch_ready = (occ < OCC_W'(DEPTH));
  assign disp_fire  = bus.dispatch_transmit & bus.dispatch_ready;
  // The FU raises busy only after latching, so our own pulse blocks back-to-back issue.
  assign issue_fire = ~bus.fu_busy & ~tx & any_grant;

  // Lowest-index free slot, one-hot.
  always_comb begin : free_pick
    logic found;
    found   = 1'b0;
    free_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!vld[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Grant-selected entry payload.
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) sel = ent[i];
    end
  end

  // Incoming entry, forwarding a same-cycle CDB broadcast into unresolved sources.
  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.operand = bus.disp_operand;
    new_ent.wbs     = bus.disp_wbs;
    new_ent.flags   = bus.disp_flags;
    new_ent.robid   = bus.disp_robid;
    for (int s = 0; s < 2; s++) begin
      new_ent.tag[s] = bus.disp_src_tag[s];
      new_ent.val[s] = bus.disp_src_val[s];
      new_ent.rdy[s] = bus.disp_src_ready[s];
      if (!bus.disp_src_ready[s] && bus.cdb_valid && bus.disp_src_tag[s] == bus.cdb_id) begin
        new_ent.rdy[s] = 1'b1;
        new_ent.val[s] = bus.cdb_val;
      end
    end
  end

  // Age matrix update: drop the issued entry's row/column, make the new entry
  // younger than every entry that survives this edge.
  always_comb begin
    older_nxt = older;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (issue_fire && (grant[i] || grant[j])) older_nxt[i][j] = 1'b0;
        if (disp_fire && free_oh[j]) older_nxt[i][j] = vld[i] & ~(issue_fire & grant[i]);
        if (disp_fire && free_oh[i]) older_nxt[i][j] = 1'b0;
      end
    end
  end

  // Entry storage, age matrix, occupancy and the registered issue stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      older       <= '0;
      occ         <= '0;
      tx          <= 1'b0;
      out_operand <= '0;
      out_depvals <= '0;
      out_wbs     <= '0;
      out_flags   <= '0;
      out_robid   <= '0;
    end else if (flush_now) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
      older <= '0;
      occ   <= '0;
      tx    <= 1'b0;
    end else begin
      tx <= issue_fire;
      if (issue_fire) begin
        out_operand <= sel.operand;
        out_depvals <= sel.val;
        out_wbs     <= sel.wbs;
        out_flags   <= sel.flags;
        out_robid   <= sel.robid;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (ent[i].valid && bus.cdb_valid) begin
          for (int s = 0; s < 2; s++) begin
            if (!ent[i].rdy[s] && ent[i].tag[s] == bus.cdb_id) begin
              ent[i].rdy[s] <= 1'b1;
              ent[i].val[s] <= bus.cdb_val;
            end
          end
        end
        if (issue_fire && grant[i]) ent[i].valid <= 1'b0;
        if (disp_fire && free_oh[i]) ent[i] <= new_ent;
      end
      older <= older_nxt;
      case ({disp_fire, issue_fire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign bus.issue_transmit = tx;
  assign bus.issue_operand  = out_operand;
  assign bus.issue_depvals  = out_depvals;
  assign bus.issue_wbs      = out_wbs;
  assign bus.issue_flags    = out_flags;
  assign bus.issue_robid    = out_robid;
  assign bus.occupancy      = occ;

endmodule

// File: tb/tb_mult_rs.sv
// Testbench for mult_rs: directed scenarios plus random traffic, checked by an
// age-ordered queue model and a scoreboard drained by an independent monitor.
module tb_mult_rs;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]      op;
    logic [7:0]      wbs;
    logic [7:0]      flags;
    logic [3:0]      robid;
    logic [1:0]      rdy;
    logic [1:0][3:0] tag;
    logic [1:0][7:0] val;
  } op_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef MULT_RS_FLUSH_EN
  logic flush = 1'b0;
`endif

  mult_rs_if #(.DEPTH(DEPTH)) bus ();

  mult_rs #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef MULT_RS_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int  n_chk  = 0;
  int  n_fail = 0;
  op_t pend[$];   // outstanding ops, oldest first
  op_t expq[$];   // predicted issues, in order
  bit  m_issue = 1'b0;
  bit  prev_tx = 1'b0;
  op_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, given the inputs held across it.
  task automatic model_step();
    op_t o;
    bit  room;
    bit  iss;
    if (!rst) return;
`ifdef MULT_RS_FLUSH_EN
    if (flush) begin
      pend.delete();
      m_issue = 1'b0;
      return;
    end
`endif
    room = (pend.size() < DEPTH);
    iss  = 1'b0;
    if (!bus.fu_busy && !m_issue) begin
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].rdy == 2'b11) begin
          expq.push_back(pend[k]);
          pend.delete(k);
          iss = 1'b1;
          break;
        end
      end
    end
    m_issue = iss;
    if (bus.cdb_valid) begin
      for (int k = 0; k < pend.size(); k++) begin
        o = pend[k];
        for (int s = 0; s < 2; s++) begin
          if (!o.rdy[s] && o.tag[s] == bus.cdb_id) begin
            o.rdy[s] = 1'b1;
            o.val[s] = bus.cdb_val;
          end
        end
        pend[k] = o;
      end
    end
    if (bus.dispatch_transmit && room) begin
      o.op    = bus.disp_operand;
      o.wbs   = bus.disp_wbs;
      o.flags = bus.disp_flags;
      o.robid = bus.disp_robid;
      for (int s = 0; s < 2; s++) begin
        o.tag[s] = bus.disp_src_tag[s];
        o.rdy[s] = 1'b0;
        o.val[s] = 8'h00;
        if (bus.disp_src_ready[s]) begin
          o.rdy[s] = 1'b1;
          o.val[s] = bus.disp_src_val[s];
        end else if (bus.cdb_valid && bus.disp_src_tag[s] == bus.cdb_id) begin
          o.rdy[s] = 1'b1;
          o.val[s] = bus.cdb_val;
        end
      end
      pend.push_back(o);
    end
  endtask

  // One clock: model the edge, check state, then drop pulse-type inputs.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("occupancy", 32'(bus.occupancy), 32'(pend.size()));
    chk("dispatch_ready", 32'(bus.dispatch_ready), 32'(pend.size() < DEPTH));
    chk("issue_timing", 32'(bus.issue_transmit), 32'(m_issue));
    bus.dispatch_transmit = 1'b0;
    bus.cdb_valid         = 1'b0;
`ifdef MULT_RS_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic disp(input logic [3:0] rid, input logic [1:0] r,
                      input logic [3:0] ta, input logic [3:0] tbg,
                      input logic [7:0] va, input logic [7:0] vb);
    bus.dispatch_transmit = 1'b1;
    bus.disp_operand      = 8'($urandom);
    bus.disp_wbs          = 8'($urandom);
    bus.disp_flags        = 8'($urandom);
    bus.disp_robid        = rid;
    bus.disp_src_ready    = r;
    bus.disp_src_tag[0]   = ta;
    bus.disp_src_tag[1]   = tbg;
    bus.disp_src_val[0]   = va;
    bus.disp_src_val[1]   = vb;
  endtask

  task automatic cdb(input logic [3:0] id, input logic [7:0] v);
    bus.cdb_valid = 1'b1;
    bus.cdb_id    = id;
    bus.cdb_val   = v;
  endtask

  // Bounded wait for the next issue pulse, then check which op it carries.
  task automatic wait_issue(input string nm, input logic [3:0] rid);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      cyc();
      seen = bus.issue_transmit;
    end
    if (!seen) chk({nm, "_timeout"}, 32'(0), 32'(1));
    else       chk(nm, 32'(bus.issue_robid), 32'(rid));
  endtask

  task automatic idle(input int n);
    for (int t = 0; t < n; t++) cyc();
  endtask

  // Scoreboard monitor: every issue pulse must match the next predicted op.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (bus.issue_transmit) begin
        chk("issue_spacing", 32'(prev_tx), 32'(0));
        if (expq.size() == 0) begin
          chk("unexpected_issue", 32'(1), 32'(0));
        end else begin
          e = expq.pop_front();
          chk("issue_robid", 32'(bus.issue_robid), 32'(e.robid));
          chk("issue_operand", 32'(bus.issue_operand), 32'(e.op));
          chk("issue_a", 32'(bus.issue_depvals[0]), 32'(e.val[0]));
          chk("issue_b", 32'(bus.issue_depvals[1]), 32'(e.val[1]));
          chk("issue_wbs", 32'(bus.issue_wbs), 32'(e.wbs));
          chk("issue_flags", 32'(bus.issue_flags), 32'(e.flags));
        end
      end
      prev_tx = bus.issue_transmit;
    end else begin
      prev_tx = 1'b0;
    end
  end

  initial begin
    bus.dispatch_transmit = 1'b0;
    bus.disp_operand      = '0;
    bus.disp_src_ready    = '0;
    bus.disp_src_tag      = '0;
    bus.disp_src_val      = '0;
    bus.disp_wbs          = '0;
    bus.disp_flags        = '0;
    bus.disp_robid        = '0;
    bus.cdb_valid         = 1'b0;
    bus.cdb_id            = '0;
    bus.cdb_val           = '0;
    bus.fu_busy           = 1'b0;

    // Reset state
    #12;
    chk("rst_occupancy", 32'(bus.occupancy), 32'(0));
    chk("rst_ready", 32'(bus.dispatch_ready), 32'(1));
    chk("rst_tx", 32'(bus.issue_transmit), 32'(0));
    chk("rst_robid", 32'(bus.issue_robid), 32'(0));
    chk("rst_depvals", 32'(bus.issue_depvals), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Both sources ready at dispatch
    disp(4'd2, 2'b11, 4'd0, 4'd0, 8'd3, 8'd5);
    cyc();
    chk("t1_no_early", 32'(bus.issue_transmit), 32'(0));
    cyc();
    chk("t1_pulse", 32'(bus.issue_transmit), 32'(1));
    chk("t1_depvals", 32'(bus.issue_depvals), 32'(16'h0503));
    chk("t1_robid", 32'(bus.issue_robid), 32'(2));
    cyc();
    chk("t1_occ", 32'(bus.occupancy), 32'(0));
    chk("t1_hold", 32'(bus.issue_robid), 32'(2));

    // Source b waits on tag 7
    disp(4'd5, 2'b01, 4'd0, 4'd7, 8'd4, 8'd0);
    cyc();
    idle(3);
    chk("t2_wait", 32'(bus.issue_transmit), 32'(0));
    cdb(4'd7, 8'd9);
    cyc();
    chk("t2_not_same", 32'(bus.issue_transmit), 32'(0));
    cyc();
    chk("t2_pulse", 32'(bus.issue_transmit), 32'(1));
    chk("t2_b", 32'(bus.issue_depvals[1]), 32'(9));
    idle(2);

    // Same-cycle dispatch and CDB forward
    disp(4'd6, 2'b01, 4'd0, 4'd4, 8'd1, 8'd0);
    cdb(4'd4, 8'h11);
    cyc();
    cyc();
    chk("t3_pulse", 32'(bus.issue_transmit), 32'(1));
    chk("t3_b", 32'(bus.issue_depvals[1]), 32'(8'h11));
    idle(2);

    // Fill while FU busy, overflow dispatch ignored, drain oldest-first
    bus.fu_busy = 1'b1;
    for (int r = 0; r < DEPTH; r++) begin
      disp(4'(r), 2'b11, 4'd0, 4'd0, 8'(r + 16), 8'(r + 32));
      cyc();
    end
    chk("t4_full", 32'(bus.dispatch_ready), 32'(0));
    disp(4'd9, 2'b11, 4'd0, 4'd0, 8'd1, 8'd1);
    cyc();
    chk("t4_ignored", 32'(bus.occupancy), 32'(DEPTH));
    bus.fu_busy = 1'b0;
    for (int r = 0; r < DEPTH; r++) wait_issue("t4_order", 4'(r));
    idle(2);

    // Older entry at higher index wins a shared wakeup
    bus.fu_busy = 1'b1;
    disp(4'd1, 2'b11, 4'd0, 4'd0, 8'd7, 8'd8);
    cyc();
    disp(4'd2, 2'b01, 4'd0, 4'd6, 8'd7, 8'd0);
    cyc();
    bus.fu_busy = 1'b0;
    wait_issue("t5_first", 4'd1);
    bus.fu_busy = 1'b1;
    disp(4'd3, 2'b01, 4'd0, 4'd6, 8'd9, 8'd0);
    cyc();
    cdb(4'd6, 8'h22);
    cyc();
    bus.fu_busy = 1'b0;
    wait_issue("t5_older", 4'd2);
    wait_issue("t5_younger", 4'd3);
    idle(2);

    // Async reset mid-wakeup with a pulse in flight
    bus.fu_busy = 1'b1;
    disp(4'd10, 2'b11, 4'd0, 4'd0, 8'd1, 8'd2);
    cyc();
    for (int r = 0; r < 3; r++) begin
      disp(4'(11 + r), 2'b01, 4'd0, 4'd8, 8'd3, 8'd0);
      cyc();
    end
    bus.fu_busy = 1'b0;
    cyc();
    chk("t6_pre_tx", 32'(bus.issue_transmit), 32'(1));
    cdb(4'd8, 8'h33);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_occ", 32'(bus.occupancy), 32'(0));
    chk("t6_rst_tx", 32'(bus.issue_transmit), 32'(0));
    pend.delete();
    expq.delete();
    m_issue = 1'b0;
    bus.cdb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(2);

`ifdef MULT_RS_FLUSH_EN
    // Flush overrides dispatch and wakeup
    bus.fu_busy = 1'b1;
    for (int r = 0; r < 3; r++) begin
      disp(4'(r), 2'b01, 4'd0, 4'd8, 8'd3, 8'd0);
      cyc();
    end
    flush = 1'b1;
    disp(4'd7, 2'b11, 4'd0, 4'd0, 8'd1, 8'd1);
    cdb(4'd8, 8'h44);
    cyc();
    chk("flush_occ", 32'(bus.occupancy), 32'(0));
    chk("flush_tx", 32'(bus.issue_transmit), 32'(0));
    bus.fu_busy = 1'b0;
    idle(3);
`endif

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 1) == 1)
        disp(4'($urandom), 2'($urandom), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) cdb(4'($urandom_range(0, 3)), 8'($urandom));
      bus.fu_busy = ($urandom_range(0, 3) == 0);
      cyc();
    end

    // Drain: broadcast every tag in use until nothing is left
    bus.fu_busy = 1'b0;
    for (int t = 0; t < 60; t++) begin
      cdb(4'(t % 4), 8'($urandom));
      cyc();
    end
    idle(4);
    chk("drain_pending", 32'(pend.size()), 32'(0));
    chk("drain_scoreboard", 32'(expq.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_rs.md
Name: mult_rs

Overview:
- Reservation station directly upstream of the multiply functional unit in the 8-bit out-of-order core.
- Buffers dispatched multiply ops until both source operands are resolved, by snooping the CDB for producer ROB tags.
- Issues the oldest ready op to the FU via its input_transmit/depvals/wbs/flags/robid interface, and only while the FU is not busy.

Parameters:
- DEPTH, 4, number of entries (2..8).
- TAG_W, 4, ROB tag width; matches robid/cdb_id.
- DATA_W, 8, operand/value width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- dispatch_transmit  in  1  dispatch valid; accepted only when dispatch_ready=1.
- dispatch_ready  out  1  not full.
- disp_operand  in  8  opcode/operand field.
- disp_src_ready  in  2  per-source: value already known.
- disp_src_tag  in  2x4  producer ROB tag per source.
- disp_src_val  in  2x8  value per source (valid when ready).
- disp_wbs  in  8  writeback select.
- disp_flags  in  8  flags.
- disp_robid  in  4  ROB id of this op.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_id  in  4  broadcasting tag.
- cdb_val  in  8  broadcast value.
- fu_busy  in  1  FU busy.
- issue_transmit  out  1  registered one-cycle issue pulse to FU input_transmit.
- issue_operand  out  8  payload.
- issue_depvals  out  2x8  payload; [0]=a, [1]=b.
- issue_wbs, issue_flags  out  8 each  payload.
- issue_robid  out  4  payload.
- occupancy  out  clog2(DEPTH)+1  valid entry count.

Behaviour:
- Reset (rst=0, async): all entries invalid; age matrix cleared; issue_transmit=0; every issue payload output=0; occupancy=0; dispatch_ready=1.
- Entry fields: valid, operand, rdy[1:0], tag[1:0], val[1:0], wbs, flags, robid.
- Age matrix: older[i][j]=1 when entry i was allocated before entry j.
- Dispatch: on a clock edge with dispatch_transmit && dispatch_ready, write the lowest-index free entry and mark it younger than all valid entries.
- dispatch_ready = (occupancy < DEPTH). It is computed from current state; a same-cycle issue does not free a slot for a same-cycle dispatch.
- Dispatch with dispatch_ready=0: dispatch is ignored and no state changes.
- Wakeup: each cycle cdb_valid=1, every valid entry source with rdy=0 and tag==cdb_id sets rdy=1 and latches val=cdb_val. Both sources of one entry may wake together.
- Dispatch/CDB same cycle: if a dispatched source has disp_src_ready=0 and disp_src_tag==cdb_id with cdb_valid=1, the source is written rdy=1, val=cdb_val.
- Eligibility: an entry is eligible only if valid and both rdy bits are registered 1. A source woken this cycle is eligible next cycle, giving 1-cycle minimum wakeup-to-issue.
- Issue: at an edge with fu_busy=0, issue_transmit currently 0, and at least one eligible entry:
  - pick the oldest eligible entry;
  - register its payload onto the issue_* outputs and set issue_transmit=1 for exactly one cycle;
  - invalidate the entry and clear its age row/column.
- Issue spacing: issue_transmit is never high on two consecutive cycles, because the FU asserts busy only after latching. Max throughput is one issue per 2 cycles. The FU also stays busy about 10 cycles, which limits practical throughput further.
- Payload outputs hold their last values while issue_transmit=0.
- No eligible entries: issue_transmit stays 0.
- Occupancy counts +1 on dispatch and -1 on issue; both in one cycle leaves it unchanged.
- Reset mid-operation: all entries are dropped and any pending issue pulse is cleared asynchronously.

Optional Feature:
- Macro: MULT_RS_FLUSH_EN.
- With the macro: adds port flush (in, 1). At a clock edge with flush=1, all entries are invalidated, occupancy=0, and issue_transmit=0. Flush overrides a dispatch or issue in the same cycle, and CDB wakeups that cycle are discarded.
- Without the macro: the port is absent and entries leave only by issue or reset.

Decomposition:
- Package rs_pkg: TAG_W, DATA_W constants and the rs_entry_t packed struct (fields as above).
- One sub-module, rs_oldest_pick: combinational. Inputs are the eligible vector and the age matrix; outputs are a one-hot grant plus any_grant.

Test Plan:
- Both sources ready at dispatch (a=3, b=5, robid=2), fu_busy=0: issue_transmit pulses 2 cycles after dispatch with depvals {3,5} and robid 2; occupancy returns to 0.
- Source b waits on tag 7: dispatch with b rdy=0, then cdb_valid with id=7, val=9 -> issue on the cycle after wakeup with depvals[1]=9; no earlier issue.
- Dispatch with b tag 4 while cdb_valid, id=4, val=0x11 in the same cycle -> entry stored ready with b=0x11 and issues normally.
- Fill DEPTH=4 with fu_busy=1 -> dispatch_ready=0 and a 5th dispatch is ignored. Release fu_busy -> entries issue oldest-first (robids 0,1,2,3), with issue pulses never adjacent.
- Two entries both made eligible by one CDB broadcast -> the older-allocated entry issues first even if it has the higher index.
- Assert rst low mid-wakeup with 3 entries valid -> occupancy=0, issue_transmit=0 immediately. With MULT_RS_FLUSH_EN, flush gives the same result on the next edge.
